// File: rtl/uart_rx_if.sv
// Parallel side of the 8N1 receiver: serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rxd,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rxd,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: start-bit qualification, mid-bit sampling LSB first,
// stop-bit check, one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            sync1_q, sync2_q;
  logic            rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      // Re-check the line at the middle of the start bit to reject short glitches.
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counting a full bit from mid-start lands every sample at mid-bit.
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWait;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWait: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames checked against an event model that predicts
// each strobe's cycle and byte from the frame timing rules.
module tb_uart_rx;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_rx_if u ();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected and observed strobe events: cycle stamp, kind (1 = valid, 0 = frame_err), data.
  int         exp_stamp[$];
  bit         exp_kind[$];
  logic [7:0] exp_data[$];
  int         obs_stamp[$];
  bit         obs_kind[$];
  logic [7:0] obs_data[$];
  int         both_hi = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) begin
    #1;
    if (u.valid) begin
      obs_stamp.push_back(cyc);
      obs_kind.push_back(1'b1);
      obs_data.push_back(u.data);
    end
    if (u.frame_err) begin
      obs_stamp.push_back(cyc);
      obs_kind.push_back(1'b0);
      obs_data.push_back(u.data);
    end
    if (u.valid && u.frame_err) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The falling edge is driven just after edge c, so the synchronizer sees it at c+1 and the
  // stop bit is sampled 2 + N/2 + 9N edges later; the strobe is visible right after that edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    exp_stamp.push_back(cyc + 3 + N / 2 + 9 * N);
    exp_kind.push_back(stop);
    if (stop) model_data = b;
    exp_data.push_back(model_data);
    u.rxd = 1'b0;
    repeat (N) step();
    for (int i = 0; i < 8; i++) begin
      u.rxd = b[i];
      repeat (N) step();
    end
    u.rxd = stop;
    repeat (N) step();
  endtask

  task automatic check_events(input string tag);
    chk($sformatf("%s_count", tag), obs_stamp.size(), exp_stamp.size());
    for (int i = 0; i < exp_stamp.size() && i < obs_stamp.size(); i++) begin
      chk($sformatf("%s_stamp%0d", tag, i), obs_stamp[i], exp_stamp[i]);
      chk($sformatf("%s_kind%0d", tag, i), 32'(obs_kind[i]), 32'(exp_kind[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
    end
    exp_stamp.delete();
    exp_kind.delete();
    exp_data.delete();
    obs_stamp.delete();
    obs_kind.delete();
    obs_data.delete();
  endtask

  int         nb;
  int         gap;
  logic [7:0] rb;
  logic [7:0] b81;

  initial begin
    u.rxd = 1'b1;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(u.data), 'h00);
    chk("rst_valid", 32'(u.valid), 0);
    chk("rst_frame_err", 32'(u.frame_err), 0);
    chk("rst_busy", 32'(u.busy), 0);
    rst = 1'b0;
    repeat (4) step();

    // Single byte
    send_frame(8'hA5, 1'b1);
    repeat (4) step();
    check_events("a5");
    chk("a5_data_hold", 32'(u.data), 'hA5);

    // Back-to-back bytes, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) step();
    if (obs_stamp.size() == 2) chk("b2b_gap", obs_stamp[1] - obs_stamp[0], 10 * N);
    check_events("b2b");

    // Four-cycle glitch: busy for exactly half a bit, no strobes
    nb    = 0;
    u.rxd = 1'b0;
    for (int i = 0; i < 4 + 2 * N; i++) begin
      if (i == 4) u.rxd = 1'b1;
      step();
      if (u.busy) nb++;
    end
    chk("glitch_busy_cycles", nb, N / 2);
    chk("glitch_busy_end", 32'(u.busy), 0);
    check_events("glitch");

    // Framing error, line held low, then released
    send_frame(8'h3C, 1'b0);
    repeat (40) step();
    u.rxd = 1'b1;
    step();
    step();
    chk("wait_busy_hi", 32'(u.busy), 1);
    step();
    chk("wait_busy_lo", 32'(u.busy), 0);
    chk("ferr_data_kept", 32'(u.data), 'hFF);
    check_events("ferr");
    repeat (3) step();
    send_frame(8'h5A, 1'b1);
    repeat (4) step();
    check_events("after_ferr");

    // Random bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom);
      gap = int'($urandom_range(N, 0));
      repeat (gap) step();
      send_frame(rb, 1'b1);
    end
    repeat (4) step();
    check_events("rand");
    chk("rand_data", 32'(u.data), 32'(model_data));

    // Reset in the middle of data bit 3 of 8'h81
    b81   = 8'h81;
    u.rxd = 1'b0;
    repeat (N) step();
    for (int i = 0; i < 3; i++) begin
      u.rxd = b81[i];
      repeat (N) step();
    end
    u.rxd = b81[3];
    repeat (N / 2) step();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    u.rxd      = 1'b1;
    model_data = 8'h00;
    chk("midrst_data", 32'(u.data), 'h00);
    chk("midrst_busy", 32'(u.busy), 0);
    repeat (2 * N) step();
    check_events("midrst");
    send_frame(8'h7E, 1'b1);
    repeat (4) step();
    check_events("after_rst");
    chk("final_data", 32'(u.data), 'h7E);
    chk("never_both", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
